db_matcher: RTL

Sequential descriptor matcher that consumes the 288-bit reference feature database (36 × 8-bit average values). On `start` it latches a candidate 36-byte descriptor, raises `matReaden` to fetch `dbValue`, accumulates the sum of absolute differences (SAD) over LANES bytes per cycle, and reports `matched` when SAD ≤ THRESH. It sits after the FAST9 descriptor extraction stage and drives the database memory's read-enable.

---
 rtl/db_pkg.sv | 26 ++
 rtl/db_sad_lanes.sv | 21 ++
 rtl/db_matcher.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/db_pkg.sv
// Shared definitions for the descriptor matcher: database geometry,
// accumulator width, FSM state encoding and the byte absolute-difference helper.
package db_pkg;

    localparam int unsigned DB_BYTES = 36;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned SAD_W    = 14;
    // Group counter width; covers up to 36 groups when LANES = 1.
    localparam int unsigned CNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACCUM,
        DONE
    } state_t;

    // Unsigned absolute difference of two bytes; always fits in a byte.
    function automatic logic [BYTE_W-1:0] abs_diff(
        input logic [BYTE_W-1:0] a,
        input logic [BYTE_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/db_sad_lanes.sv
// Combinational sum of absolute differences over one LANES-byte group.
module db_sad_lanes
    import db_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic [LANES*BYTE_W-1:0] feat_grp,
    input  logic [LANES*BYTE_W-1:0] db_grp,
    output logic [SAD_W-1:0]        sad
);

    // Add the per-byte absolute differences across all lanes.
    always_comb begin
        sad = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sad = sad + SAD_W'(abs_diff(feat_grp[k*BYTE_W +: BYTE_W],
                                        db_grp[k*BYTE_W +: BYTE_W]));
        end
    end

endmodule

// File: rtl/db_matcher.sv
// Sequential descriptor matcher: latches a 36-byte candidate on start, reads
// the reference database vector once, accumulates SAD over LANES bytes per
// cycle (byte 35 downward) and reports matched = (SAD <= THRESH).
// Optional feature macro: DBMATCH_EARLY_EXIT_EN -- finish as soon as the
// running SAD exceeds THRESH, reporting the partial sum.
module db_matcher
    import db_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned THRESH = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DB_BYTES*BYTE_W-1:0]   featValue,
    output logic                         matReaden,
    input  logic [DB_BYTES*BYTE_W-1:0]   dbValue,
    output logic                         busy,
    output logic                         done,
    output logic                         matched,
    output logic [SAD_W-1:0]             sadValue
);

    localparam int unsigned       VEC_W    = DB_BYTES * BYTE_W;
    localparam int unsigned       GRP_W    = LANES * BYTE_W;
    localparam int unsigned       GROUPS   = DB_BYTES / LANES;
    localparam logic [CNT_W-1:0]  LAST_GRP = CNT_W'(GROUPS - 1);
    localparam logic [SAD_W-1:0]  THRESH_V = SAD_W'(THRESH);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   feat_q, feat_d;
    logic [VEC_W-1:0]   db_q, db_d;
    logic [SAD_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   grp_q, grp_d;
    logic               matreaden_q, matreaden_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               matched_q, matched_d;
    logic [SAD_W-1:0]   sad_q, sad_d;

    logic [SAD_W-1:0]   lane_sad;
    logic [SAD_W-1:0]   sum_upd;
    logic               last_step;

    // The operand vectors shift up by one group per ACCUM cycle, so the
    // current group always sits in the top bytes; this avoids a wide
    // variable-index mux over the 288-bit vectors.
    db_sad_lanes #(
        .LANES (LANES)
    ) u_sad_lanes (
        .feat_grp (feat_q[VEC_W-1 -: GRP_W]),
        .db_grp   (db_q[VEC_W-1 -: GRP_W]),
        .sad      (lane_sad)
    );

    // Running sum including the group presented this cycle, and whether
    // this ACCUM cycle is the final one.
    always_comb begin
        sum_upd   = sum_q + lane_sad;
        last_step = (grp_q == LAST_GRP);
`ifdef DBMATCH_EARLY_EXIT_EN
        if (sum_upd > THRESH_V) begin
            last_step = 1'b1;
        end
`endif
    end

    // Next-state and registered-output computation for the matcher FSM.
    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        db_d        = db_q;
        sum_d       = sum_q;
        grp_d       = grp_q;
        matreaden_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        matched_d   = matched_q;
        sad_d       = sad_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    feat_d      = featValue;
                    sum_d       = '0;
                    grp_d       = '0;
                    matched_d   = 1'b0;
                    sad_d       = '0;
                    matreaden_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                db_d    = dbValue;
                state_d = ACCUM;
            end
            ACCUM: begin
                sum_d  = sum_upd;
                feat_d = feat_q << GRP_W;
                db_d   = db_q << GRP_W;
                grp_d  = grp_q + CNT_W'(1);
                if (last_step) begin
                    done_d    = 1'b1;
                    matched_d = (sum_upd <= THRESH_V);
                    sad_d     = sum_upd;
                    state_d   = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            feat_q      <= '0;
            db_q        <= '0;
            sum_q       <= '0;
            grp_q       <= '0;
            matreaden_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            matched_q   <= 1'b0;
            sad_q       <= '0;
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            db_q        <= db_d;
            sum_q       <= sum_d;
            grp_q       <= grp_d;
            matreaden_q <= matreaden_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            matched_q   <= matched_d;
            sad_q       <= sad_d;
        end
    end

    assign matReaden = matreaden_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign matched   = matched_q;
    assign sadValue  = sad_q;

endmodule
